// File: rtl/controller_poll_arbiter.sv
// Periodic two-port controller poller sharing one serial reader; turns button state changes
// into press/release events queued in a small FIFO.
module controller_poll_arbiter #(
  parameter int unsigned POLL_PERIOD = 16000,
  parameter int unsigned TIMEOUT     = 12000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       rd_start,
  output logic       rd_sel,
  input  logic       rd_valid,
  input  logic [7:0] rd_buttons,
  output logic [7:0] btn_p0,
  output logic [7:0] btn_p1,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_port,
  output logic [7:0] ev_pressed,
  output logic [7:0] ev_released,
  output logic [1:0] to_err,
  output logic       ev_overflow,
  output logic [7:0] overrun_cnt
);

  localparam int unsigned PerW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [PerW-1:0] PerMax = PerW'(POLL_PERIOD - 1);
  localparam logic [ToW-1:0]  ToMax  = ToW'(TIMEOUT - 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] Full   = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1} state_e;

  state_e state_q, state_d;

  logic [PerW-1:0] per_q, per_d;
  logic [ToW-1:0]  wait_q, wait_d;
  logic [7:0]      btn_p0_q, btn_p0_d, btn_p1_q, btn_p1_d;
  logic [1:0]      to_err_q, to_err_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      overrun_q, overrun_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [16:0]     mem_q [FIFO_DEPTH];

  logic        tick, in_wait, port, timeout, res_ok, res_to, advance;
  logic        push, pop, push_ok;
  logic [7:0]  old_btn;
  logic [16:0] new_ev, head;

  assign tick    = enable && (per_q == PerMax);
  assign in_wait = (state_q == StWait0) || (state_q == StWait1);
  assign port    = (state_q == StWait1);
  assign timeout = in_wait && (wait_q == ToMax);
  // A completion coinciding with the timeout cycle wins over the timeout.
  assign res_ok  = in_wait && rd_valid;
  assign res_to  = timeout && !rd_valid;
  assign advance = res_ok || timeout;

  assign old_btn = port ? btn_p1_q : btn_p0_q;
  assign new_ev  = {port, rd_buttons & ~old_btn, old_btn & ~rd_buttons};
  assign push    = res_ok && (rd_buttons != old_btn);
  assign pop     = ev_valid && ev_ready;
  assign push_ok = push && ((count_q != Full) || pop);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tick) state_d = StReq0;
      StReq0:  state_d = StWait0;
      StWait0: if (advance) state_d = StReq1;
      StReq1:  state_d = StWait1;
      StWait1: if (advance) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    rd_start = 1'b0;
    rd_sel   = 1'b0;
    unique case (state_q)
      StReq0:  rd_start = 1'b1;
      StReq1:  begin rd_start = 1'b1; rd_sel = 1'b1; end
      StWait1: rd_sel = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    per_d     = (!enable || tick) ? '0 : per_q + 1'b1;
    wait_d    = (in_wait && !advance) ? wait_q + 1'b1 : '0;
    overrun_d = overrun_q;
    if (tick && (state_q != StIdle) && (overrun_q != 8'hFF)) overrun_d = overrun_q + 1'b1;

    btn_p0_d = btn_p0_q;
    btn_p1_d = btn_p1_q;
    if (res_ok && !port) btn_p0_d = rd_buttons;
    if (res_ok && port)  btn_p1_d = rd_buttons;

    to_err_d = to_err_q;
    if (res_to) to_err_d[port] = 1'b1;
    ovf_d = ovf_q || (push && !push_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q     <= '0;
      wait_q    <= '0;
      overrun_q <= '0;
      btn_p0_q  <= '0;
      btn_p1_q  <= '0;
      to_err_q  <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      per_q     <= per_d;
      wait_q    <= wait_d;
      overrun_q <= overrun_d;
      btn_p0_q  <= btn_p0_d;
      btn_p1_q  <= btn_p1_d;
      to_err_q  <= to_err_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= new_ev;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign ev_valid    = (count_q != '0);
  assign ev_port     = ev_valid & head[16];
  assign ev_pressed  = head[15:8] & {8{ev_valid}};
  assign ev_released = head[7:0] & {8{ev_valid}};
  assign btn_p0      = btn_p0_q;
  assign btn_p1      = btn_p1_q;
  assign to_err      = to_err_q;
  assign ev_overflow = ovf_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_controller_poll_arbiter.sv
// Directed + randomized bench for controller_poll_arbiter against a round-level reference model.
module tb_controller_poll_arbiter;
  localparam int unsigned P = 100;
  localparam int unsigned T = 160;
  localparam int unsigned D = 4;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, rd_valid = 1'b0, ev_ready = 1'b0;
  logic [7:0] rd_buttons = 8'h00;
  logic       rd_start, rd_sel, ev_valid, ev_port, ev_overflow;
  logic [7:0] btn_p0, btn_p1, ev_pressed, ev_released, overrun_cnt;
  logic [1:0] to_err;

  controller_poll_arbiter #(.POLL_PERIOD(P), .TIMEOUT(T), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rd_start(rd_start), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_buttons(rd_buttons), .btn_p0(btn_p0), .btn_p1(btn_p1),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_port(ev_port), .ev_pressed(ev_pressed),
    .ev_released(ev_released), .to_err(to_err), .ev_overflow(ev_overflow),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0, cyc = 0;
  int          tick_base, last_end, ovr_exp;
  logic [7:0]  mbtn [2];
  logic [1:0]  err_exp;
  bit          ovf_exp, pop_on_valid;
  logic [16:0] q [$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ticks_upto(input int x);
    return (x - tick_base) / int'(P);
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, {31'd0, rd_start}, 0);
    chk({tag, "_sel"}, {31'd0, rd_sel}, 0);
    chk({tag, "_btn"}, {16'd0, btn_p0, btn_p1}, 0);
    chk({tag, "_ev"}, {14'd0, ev_valid, ev_port, ev_pressed, ev_released}, 0);
    chk({tag, "_flags"}, {21'd0, to_err, ev_overflow, overrun_cnt}, 0);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (rd_start !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic serve(input bit port, input int gap, input bit resp, input int lat,
                       input logic [7:0] val, input bit en_off);
    int          n;
    logic [7:0]  old;
    logic [16:0] ev;
    bit          popped;
    wait_start(n);
    chk("start_gap", n, gap);
    chk("start_sel", {31'd0, rd_sel}, {31'd0, port});
    if (en_off) enable = 1'b0;
    step();
    chk("start_one_cycle", {31'd0, rd_start}, 0);
    chk("sel_hold", {31'd0, rd_sel}, {31'd0, port});
    old = mbtn[port];
    if (resp) begin
      repeat (lat - 1) step();
      popped = 1'b0;
      if (pop_on_valid && q.size() > 0) begin
        chk("head_before_pop", {15'd0, ev_port, ev_pressed, ev_released}, {15'd0, q[0]});
        ev_ready = 1'b1;
        popped = 1'b1;
      end
      rd_valid   = 1'b1;
      rd_buttons = val;
      step();
      rd_valid   = 1'b0;
      ev_ready   = 1'b0;
      rd_buttons = 8'($urandom);
      if (popped) ev = q.pop_front();
      if (val !== old) begin
        ev = {port, val & ~old, old & ~val};
        if (q.size() < int'(D)) q.push_back(ev);
        else ovf_exp = 1'b1;
      end
      mbtn[port] = val;
    end else begin
      repeat (T - 1) step();
      chk("to_err_before", {30'd0, to_err}, {30'd0, err_exp});
      step();
      err_exp[port] = 1'b1;
      chk("to_err_after", {30'd0, to_err}, {30'd0, err_exp});
    end
    chk(port ? "btn_p1" : "btn_p0", {24'd0, port ? btn_p1 : btn_p0}, {24'd0, mbtn[port]});
    chk("ev_valid", {31'd0, ev_valid}, {31'd0, q.size() != 0});
    if (q.size() > 0)
      chk("head", {15'd0, ev_port, ev_pressed, ev_released}, {15'd0, q[0]});
    chk("overflow", {31'd0, ev_overflow}, {31'd0, ovf_exp});
  endtask

  task automatic round(input int lat0, input bit r0, input logic [7:0] v0,
                       input int lat1, input bit r1, input logic [7:0] v1, input bit en_off);
    int s;
    s = tick_base + int'(P) * ((last_end - tick_base) / int'(P) + 1);
    serve(1'b0, s - cyc, r0, lat0, v0, en_off);
    serve(1'b1, 0, r1, lat1, v1, 1'b0);
    last_end = cyc;
    if (!en_off) begin
      ovr_exp = ovr_exp + ticks_upto(last_end) - ticks_upto(s);
      if (ovr_exp > 255) ovr_exp = 255;
    end
    chk("overrun_cnt", {24'd0, overrun_cnt}, ovr_exp);
  endtask

  task automatic drain();
    logic [16:0] ev;
    while (q.size() > 0) begin
      chk("drain_valid", {31'd0, ev_valid}, 1);
      chk("drain_head", {15'd0, ev_port, ev_pressed, ev_released}, {15'd0, q[0]});
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      ev = q.pop_front();
    end
    chk("drain_empty", {14'd0, ev_valid, ev_port, ev_pressed, ev_released}, 0);
  endtask

  task automatic model_reset();
    mbtn[0] = 8'h00;
    mbtn[1] = 8'h00;
    err_exp = 2'b00;
    ovf_exp = 1'b0;
    ovr_exp = 0;
    q.delete();
    tick_base = cyc;
    last_end  = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, l0, l1;
    logic [7:0] v0, v1;
    pop_on_valid = 1'b0;
    step();
    step();
    chk_reset_outs("in_reset");
    enable = 1'b1;
    rst    = 1'b0;
    model_reset();

    // Basic vector: first round one full period after reset release.
    round(50, 1, 8'h80, 50, 1, 8'h01, 0);
    chk("first_event", {15'd0, ev_port, ev_pressed, ev_released}, {15'd0, 1'b0, 8'h80, 8'h00});
    drain();
    round(30, 1, 8'h40, 20, 1, 8'h01, 0);
    chk("change_event", {15'd0, ev_port, ev_pressed, ev_released}, {15'd0, 1'b0, 8'h40, 8'h80});
    drain();
    round(10, 1, 8'h40, 10, 1, 8'h01, 0);
    chk("repeat_no_event", {31'd0, ev_valid}, 0);

    // Completion strobe while idle must be ignored.
    rd_valid   = 1'b1;
    rd_buttons = 8'hFF;
    step();
    rd_valid = 1'b0;
    chk("idle_valid_btn", {16'd0, btn_p0, btn_p1}, {16'd0, mbtn[0], mbtn[1]});
    chk("idle_valid_ev", {31'd0, ev_valid}, 0);

    // Port 0 answers on the timeout cycle (valid), port 1 never answers.
    round(T, 1, 8'h0F, 1, 0, 8'h00, 0);
    chk("timeout_flags", {30'd0, to_err}, 2);
    drain();

    // Five changing results with no consumer, then a push that coincides with a pop.
    round(5, 1, 8'h11, 5, 1, 8'h22, 0);
    round(5, 1, 8'h33, 5, 1, 8'h44, 0);
    round(5, 1, 8'h55, 5, 1, 8'h44, 0);
    chk("overflow_set", {31'd0, ev_overflow}, 1);
    pop_on_valid = 1'b1;
    round(5, 1, 8'h66, 5, 1, 8'h44, 0);
    pop_on_valid = 1'b0;
    drain();

    for (int i = 0; i < 12; i++) begin
      l0 = 1 + int'($urandom % 40);
      l1 = 1 + int'($urandom % 40);
      v0 = ($urandom % 4 == 0) ? mbtn[0] : 8'($urandom);
      v1 = ($urandom % 4 == 0) ? mbtn[1] : 8'($urandom);
      round(l0, 1, v0, l1, 1, v1, 0);
      if ($urandom % 2 == 1) drain();
    end
    drain();

    // Enable dropped mid-round: round completes, then no further rounds.
    round(10, 1, 8'hA5, 10, 1, 8'h5A, 1);
    n = 0;
    repeat (300) begin
      step();
      if (rd_start === 1'b1) n++;
    end
    chk("no_start_disabled", n, 0);
    enable    = 1'b1;
    tick_base = cyc;
    last_end  = cyc;
    round(7, 1, 8'hA5, 9, 1, 8'h5B, 0);
    drain();

    // Asynchronous reset during WAIT0.
    s = tick_base + int'(P) * ((last_end - tick_base) / int'(P) + 1);
    wait_start(n);
    chk("pre_reset_gap", n, s - cyc + n);
    repeat (5) step();
    #2 rst = 1'b1;
    #1 chk_reset_outs("async_reset");
    step();
    step();
    rst = 1'b0;
    model_reset();
    round(50, 1, 8'h80, 50, 1, 8'h01, 0);
    drain();

    // Reader slower than the poll period: overrun counting and saturation.
    for (int i = 0; i < 90; i++) round(150, 1, mbtn[0], 150, 1, mbtn[1], 0);
    chk("overrun_saturated", {24'd0, overrun_cnt}, 255);
    chk("final_err", {30'd0, to_err}, {30'd0, err_exp});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
